// File: rtl/breakout_game_ctrl.sv
// Breakout per-frame sequencer: ball/paddle motion, collisions,
// brick shadow map, score, lives and win/lose status.
module breakout_game_ctrl #(
    parameter int BALL_SIZE    = 7,
    parameter int BALL_STEP    = 2,
    parameter int PADDLE_STEP  = 4,
    parameter int PADDLE_WIDTH = 100,
    parameter int PADDLE_Y     = 440,
    parameter int START_X      = 316,
    parameter int START_Y      = 300,
    parameter int LIVES        = 3
) (
    input  logic       CLK_25MH,
    input  logic       reset_n,
    input  logic [9:0] hor_count,
    input  logic [9:0] ver_count,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_launch,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_pos,
    output logic       erase_enable,
    output logic [5:0] erase_pos,
    output logic       vga_reset,
    output logic [3:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       game_won
);
    typedef enum logic [3:0] {
        S_INIT, S_SERVE, S_WAIT, S_WALL, S_PADDLE,
        S_SCAN, S_ERASE, S_MOVE, S_LOST, S_OVER
    } state_t;

    state_t      state, state_nx;
    logic [9:0]  ball_x_nx, ball_y_nx, paddle_nx, paddle_mv;
    logic        dx, dx_nx, dy, dy_nx;
    logic [9:0]  active, active_nx;
    logic [3:0]  idx, idx_nx, hit_idx, hit_idx_nx;
    logic [3:0]  score_nx;
    logic [1:0]  lives_nx;
    logic        over_nx, won_nx, erase_en_nx, vga_reset_nx;
    logic [5:0]  erase_pos_nx;
    logic        frame_tick, brick_hit, paddle_hit;
    logic [10:0] bx, by, bxs, bys, brk_x0, brk_y0, px;

    assign frame_tick = (ver_count == 10'd480) && (hor_count == 10'd0);
    assign bx  = {1'b0, ball_x};
    assign by  = {1'b0, ball_y};
    assign bxs = bx + 11'(BALL_SIZE);
    assign bys = by + 11'(BALL_SIZE);
    assign px  = {1'b0, paddle_pos};

    always_comb begin
        unique case (idx)
            4'd0, 4'd5: brk_x0 = 11'd40;
            4'd1, 4'd6: brk_x0 = 11'd160;
            4'd2, 4'd7: brk_x0 = 11'd280;
            4'd3, 4'd8: brk_x0 = 11'd400;
            default:    brk_x0 = 11'd520;
        endcase
    end

    assign brk_y0 = (idx < 4'd5) ? 11'd40 : 11'd90;

    assign brick_hit = active[idx]
        && (bxs >= brk_x0) && (bx <= brk_x0 + 11'd80)
        && (bys >= brk_y0) && (by <= brk_y0 + 11'd30);

    assign paddle_hit = dy
        && (bys >= 11'(PADDLE_Y))
        && (by <= 11'(PADDLE_Y + 9))
        && (bxs >= px)
        && (bx <= px + 11'(PADDLE_WIDTH));

    // Opposing buttons cancel; motion clamps at both screen edges.
    always_comb begin
        paddle_mv = paddle_pos;
        if (btn_left && !btn_right) begin
            if (paddle_pos < 10'(PADDLE_STEP))
                paddle_mv = '0;
            else
                paddle_mv = paddle_pos - 10'(PADDLE_STEP);
        end else if (btn_right && !btn_left) begin
            if (px + 11'(PADDLE_STEP) > 11'(640 - PADDLE_WIDTH))
                paddle_mv = 10'(640 - PADDLE_WIDTH);
            else
                paddle_mv = paddle_pos + 10'(PADDLE_STEP);
        end
    end

    always_comb begin
        state_nx     = state;
        ball_x_nx    = ball_x;
        ball_y_nx    = ball_y;
        paddle_nx    = paddle_pos;
        dx_nx        = dx;
        dy_nx        = dy;
        active_nx    = active;
        idx_nx       = idx;
        hit_idx_nx   = hit_idx;
        score_nx     = score;
        lives_nx     = lives;
        over_nx      = game_over;
        won_nx       = game_won;
        erase_en_nx  = 1'b0;
        erase_pos_nx = erase_pos;
        vga_reset_nx = 1'b0;
        unique case (state)
            S_INIT: begin
                vga_reset_nx = 1'b1;
                active_nx    = '1;
                score_nx     = '0;
                state_nx     = S_SERVE;
            end
            S_SERVE: begin
                ball_x_nx = 10'(START_X);
                ball_y_nx = 10'(START_Y);
                dx_nx     = 1'b1;
                dy_nx     = 1'b0;
                if (frame_tick)
                    paddle_nx = paddle_mv;
                if (btn_launch)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (frame_tick)
                    state_nx = S_WALL;
            end
            S_WALL: begin
                if (!dx && ball_x < 10'(BALL_STEP))
                    dx_nx = 1'b1;
                else if (dx && bxs + 11'(BALL_STEP) > 11'd639)
                    dx_nx = 1'b0;
                state_nx = S_PADDLE;
                if (!dy && ball_y < 10'(BALL_STEP))
                    dy_nx = 1'b1;
                else if (dy && bys + 11'(BALL_STEP) > 11'd479)
                    state_nx = S_LOST;
            end
            S_PADDLE: begin
                if (paddle_hit)
                    dy_nx = 1'b0;
                idx_nx   = '0;
                state_nx = S_SCAN;
            end
            S_SCAN: begin
                if (brick_hit) begin
                    dy_nx      = ~dy;
                    hit_idx_nx = idx;
                    state_nx   = S_ERASE;
                end else if (idx == 4'd9) begin
                    state_nx = S_MOVE;
                end else begin
                    idx_nx = idx + 4'd1;
                end
            end
            S_ERASE: begin
                erase_en_nx        = 1'b1;
                erase_pos_nx       = {2'b00, hit_idx};
                active_nx[hit_idx] = 1'b0;
                score_nx           = score + 4'd1;
                if (score == 4'd9) begin
                    over_nx  = 1'b1;
                    won_nx   = 1'b1;
                    state_nx = S_OVER;
                end else begin
                    state_nx = S_MOVE;
                end
            end
            S_MOVE: begin
                ball_x_nx = dx ? ball_x + 10'(BALL_STEP)
                               : ball_x - 10'(BALL_STEP);
                ball_y_nx = dy ? ball_y + 10'(BALL_STEP)
                               : ball_y - 10'(BALL_STEP);
                paddle_nx = paddle_mv;
                state_nx  = S_WAIT;
            end
            S_LOST: begin
                lives_nx = lives - 2'd1;
                if (lives == 2'd1) begin
                    over_nx  = 1'b1;
                    won_nx   = 1'b0;
                    state_nx = S_OVER;
                end else begin
                    ball_x_nx = 10'(START_X);
                    ball_y_nx = 10'(START_Y);
                    dx_nx     = 1'b1;
                    dy_nx     = 1'b0;
                    state_nx  = S_SERVE;
                end
            end
            S_OVER: begin
                if (btn_launch) begin
                    lives_nx = 2'(LIVES);
                    over_nx  = 1'b0;
                    won_nx   = 1'b0;
                    state_nx = S_INIT;
                end
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge CLK_25MH) begin
        if (!reset_n) begin
            state        <= S_INIT;
            ball_x       <= 10'(START_X);
            ball_y       <= 10'(START_Y);
            paddle_pos   <= 10'd270;
            dx           <= 1'b1;
            dy           <= 1'b0;
            active       <= '1;
            idx          <= '0;
            hit_idx      <= '0;
            score        <= '0;
            lives        <= 2'(LIVES);
            game_over    <= 1'b0;
            game_won     <= 1'b0;
            erase_enable <= 1'b0;
            erase_pos    <= '0;
            vga_reset    <= 1'b0;
        end else begin
            state        <= state_nx;
            ball_x       <= ball_x_nx;
            ball_y       <= ball_y_nx;
            paddle_pos   <= paddle_nx;
            dx           <= dx_nx;
            dy           <= dy_nx;
            active       <= active_nx;
            idx          <= idx_nx;
            hit_idx      <= hit_idx_nx;
            score        <= score_nx;
            lives        <= lives_nx;
            game_over    <= over_nx;
            game_won     <= won_nx;
            erase_enable <= erase_en_nx;
            erase_pos    <= erase_pos_nx;
            vga_reset    <= vga_reset_nx;
        end
    end
endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Frame-level bench for breakout_game_ctrl: a game model predicts
// every frame's outputs and brick erasures, scored via queues.
module tb_breakout_game_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] hor_count = 10'd1;
    logic [9:0] ver_count = 10'd0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_launch = 1'b0;
    logic [9:0] ball_x, ball_y, paddle_pos;
    logic       erase_enable, vga_reset, game_over, game_won;
    logic [5:0] erase_pos;
    logic [3:0] score;
    logic [1:0] lives;

    breakout_game_ctrl dut (
        .CLK_25MH    (clk),
        .reset_n     (reset_n),
        .hor_count   (hor_count),
        .ver_count   (ver_count),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_launch  (btn_launch),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .paddle_pos  (paddle_pos),
        .erase_enable(erase_enable),
        .erase_pos   (erase_pos),
        .vga_reset   (vga_reset),
        .score       (score),
        .lives       (lives),
        .game_over   (game_over),
        .game_won    (game_won)
    );

    always #20 clk = ~clk;

    typedef struct {
        int x; int y; int p; int sc; int lv; int ov; int wn;
    } exp_t;

    exp_t sbq[$];
    int   exp_erase[$];
    int   obs_erase[$];
    int   vga_hi = 0;
    int   exp_vga = 0;
    int   checks = 0;
    int   errors = 0;

    // model state: mst 0=serve 1=play 2=over; mdy 1 means moving down
    int   mx, my, mp, msc, mlv, mst;
    bit   mdx, mdy, mov, mwn;
    bit [9:0] mact;

    always @(negedge clk) begin
        if (erase_enable === 1'b1) obs_erase.push_back(int'(erase_pos));
        if (vga_reset === 1'b1) vga_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 316; my = 300; mp = 270; msc = 0; mlv = 3; mst = 0;
        mdx = 1; mdy = 0; mov = 0; mwn = 0; mact = '1;
    endtask

    function automatic int pstep(int p, bit l, bit r);
        if (l && !r) return (p < 4) ? 0 : p - 4;
        if (r && !l) return (p + 4 > 540) ? 540 : p + 4;
        return p;
    endfunction

    task automatic model_tick(input bit l, input bit r);
        bit lost = 0;
        bit hit = 0;
        int x0, y0;
        if (mst == 0) begin
            mp = pstep(mp, l, r);
        end else if (mst == 1) begin
            if (!mdx && mx < 2) mdx = 1;
            else if (mdx && mx + 9 > 639) mdx = 0;
            if (!mdy && my < 2) mdy = 1;
            else if (mdy && my + 9 > 479) lost = 1;
            if (lost) begin
                mlv--;
                if (mlv == 0) begin
                    mst = 2; mov = 1; mwn = 0;
                end else begin
                    mx = 316; my = 300; mdx = 1; mdy = 0; mst = 0;
                end
            end else begin
                if (mdy && my + 7 >= 440 && my <= 449 &&
                    mx + 7 >= mp && mx <= mp + 100) mdy = 0;
                for (int i = 0; i < 10; i++) begin
                    x0 = 40 + 120 * (i % 5);
                    y0 = (i < 5) ? 40 : 90;
                    if (!hit && mact[i] && mx + 7 >= x0 && mx <= x0 + 80 &&
                        my + 7 >= y0 && my <= y0 + 30) begin
                        hit = 1; mdy = !mdy; mact[i] = 0; msc++;
                        exp_erase.push_back(i);
                    end
                end
                if (msc == 10) begin
                    mst = 2; mov = 1; mwn = 1;
                end else begin
                    mx += mdx ? 2 : -2;
                    my += mdy ? 2 : -2;
                    mp = pstep(mp, l, r);
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.x = mx; e.y = my; e.p = mp; e.sc = msc;
        e.lv = mlv; e.ov = int'(mov); e.wn = int'(mwn);
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk("ball_x", ball_x, e.x);
        chk("ball_y", ball_y, e.y);
        chk("paddle_pos", paddle_pos, e.p);
        chk("score", score, e.sc);
        chk("lives", lives, e.lv);
        chk("game_over", game_over, e.ov);
        chk("game_won", game_won, e.wn);
        chk("erase_count", obs_erase.size(), exp_erase.size());
        while (exp_erase.size() > 0 && obs_erase.size() > 0)
            chk("erase_pos", obs_erase.pop_front(), exp_erase.pop_front());
        obs_erase.delete();
        exp_erase.delete();
        chk("vga_reset_pulses", vga_hi, exp_vga);
    endtask

    task automatic frame(input bit l, input bit r);
        btn_left = l; btn_right = r;
        model_tick(l, r);
        push_exp();
        @(negedge clk); ver_count = 10'd480; hor_count = 10'd0;
        @(negedge clk); ver_count = 10'd0;   hor_count = 10'd1;
        repeat (15) @(negedge clk);
        pop_check();
    endtask

    task automatic press_launch();
        if (mst == 0) begin
            mst = 1;
        end else if (mst == 2) begin
            model_reset();
            mp = paddle_pos_hold;
            exp_vga++;
        end
        push_exp();
        @(negedge clk); btn_launch = 1'b1;
        @(negedge clk); btn_launch = 1'b0;
        repeat (3) @(negedge clk);
        pop_check();
    endtask

    int paddle_pos_hold;

    task automatic play(input int n, input bit avoid);
        bit l, r;
        int c, b;
        for (int f = 0; f < n; f++) begin
            if (mst == 2) break;
            if (mst == 0) press_launch();
            c = mp + 50; b = mx + 4;
            if (avoid) begin
                l = (mx >= 270); r = !l;
            end else begin
                r = (c + 4 < b); l = (c > b + 4);
            end
            frame(l, r);
            paddle_pos_hold = mp;
        end
    endtask

    initial begin
        model_reset();
        paddle_pos_hold = mp;
        repeat (2) @(negedge clk);
        chk("rst_ball_x", ball_x, 316);
        chk("rst_ball_y", ball_y, 300);
        chk("rst_paddle", paddle_pos, 270);
        chk("rst_erase_en", erase_enable, 0);
        chk("rst_erase_pos", erase_pos, 0);
        chk("rst_vga_reset", vga_reset, 0);
        chk("rst_score", score, 0);
        chk("rst_lives", lives, 3);
        chk("rst_over", game_over, 0);
        chk("rst_won", game_won, 0);
        reset_n = 1'b1;
        exp_vga = 1;
        repeat (3) @(negedge clk);
        chk("init_vga_pulse", vga_hi, exp_vga);

        for (int f = 0; f < 100; f++) frame(1, 0);
        chk("paddle_left_clamp", paddle_pos, 0);
        for (int f = 0; f < 5; f++) frame(1, 1);
        for (int f = 0; f < 3; f++) frame(0, 0);
        for (int f = 0; f < 20; f++) frame(0, 1);
        chk("paddle_right_20", paddle_pos, 80);
        paddle_pos_hold = mp;

        press_launch();
        play(1000, 0);
        play(2000, 1);
        chk("end_game_over", game_over, 1);
        chk("end_game_won", game_won, int'(mwn));
        frame(1, 0);

        press_launch();
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);
        chk("restart_over", game_over, 0);

        press_launch();
        @(negedge clk); ver_count = 10'd480; hor_count = 10'd0;
        @(negedge clk); ver_count = 10'd0;   hor_count = 10'd1;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midscan_ball_x", ball_x, 316);
        chk("midscan_ball_y", ball_y, 300);
        chk("midscan_paddle", paddle_pos, 270);
        chk("midscan_erase_en", erase_enable, 0);
        chk("midscan_score", score, 0);
        chk("midscan_lives", lives, 3);
        reset_n = 1'b1;
        model_reset();
        exp_vga++;
        obs_erase.delete();
        repeat (3) @(negedge clk);
        frame(0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
